// File: rtl/divider_check_mul_seq_if.sv
// -----------------------------------------------------------------------------
// divider_check_mul_seq_if
// Handshake bundle for the divider round-trip checker.
//   Input side : in_valid / in_ready, operands in_q (quotient), in_b (divisor),
//                in_r (remainder).
//   Output side: out_valid / out_ready, out_a (rebuilt dividend), out_ovf,
//                out_badrem, out_div0.
// Modports:
//   master - the operand producer / result consumer (drives in_*, out_ready)
//   slave  - the checker itself
// -----------------------------------------------------------------------------
interface divider_check_mul_seq_if #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_A-1:0] in_q;
    logic [WIDTH_B-1:0] in_b;
    logic [WIDTH_A-1:0] in_r;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_A-1:0] out_a;
    logic               out_ovf;
    logic               out_badrem;
    logic               out_div0;

    modport master (
        output in_valid, in_q, in_b, in_r, out_ready,
        input  in_ready, out_valid, out_a, out_ovf, out_badrem, out_div0
    );

    modport slave (
        input  in_valid, in_q, in_b, in_r, out_ready,
        output in_ready, out_valid, out_a, out_ovf, out_badrem, out_div0
    );
endinterface

// File: rtl/divider_check_mul_seq.sv
// -----------------------------------------------------------------------------
// divider_check_mul_seq
// Round-trip check for a WIDTH_A / WIDTH_B divider: rebuilds A = Q*B + R with
// a fixed-latency shift-add multiplier and flags illegal divider outputs.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - divider_check_mul_seq_if.slave (operand and result handshakes)
// Operands are latched on acceptance; the result appears WIDTH_B+1 cycles
// later and is held stable until out_ready is seen.
// -----------------------------------------------------------------------------
module divider_check_mul_seq #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    divider_check_mul_seq_if.slave  bus
);
    localparam int ACC_W = WIDTH_A + WIDTH_B;
    localparam int CNT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_B - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [ACC_W-1:0]   acc_q,        acc_d;
    logic [ACC_W-1:0]   mcand_q,      mcand_d;
    logic [WIDTH_B-1:0] mplier_q,     mplier_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               out_valid_q,  out_valid_d;
    logic [WIDTH_A-1:0] out_a_q,      out_a_d;
    logic               out_ovf_q,    out_ovf_d;
    logic               out_badrem_q, out_badrem_d;
    logic               out_div0_q,   out_div0_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_ovf_q    <= 1'b0;
            out_badrem_q <= 1'b0;
            out_div0_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_ovf_q    <= out_ovf_d;
            out_badrem_q <= out_badrem_d;
            out_div0_q   <= out_div0_d;
        end
    end

    // Next-state and datapath logic for the IDLE -> MUL -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_ovf_d    = out_ovf_q;
        out_badrem_d = out_badrem_q;
        out_div0_d   = out_div0_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Seeding acc with R folds the "+R" into the multiply.
                    acc_d        = ACC_W'(bus.in_r);
                    mcand_d      = ACC_W'(bus.in_q);
                    mplier_d     = bus.in_b;
                    cnt_d        = '0;
                    out_badrem_d = (bus.in_r >= WIDTH_A'(bus.in_b));
                    out_div0_d   = (bus.in_b == '0);
                    state_d      = ST_MUL;
                end else begin
                    state_d      = ST_IDLE;
                end
            end

            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Fixed latency: all WIDTH_B bits are walked even if mplier is 0.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end

            ST_DONE: begin
                // First DONE cycle registers the result; it then holds while stalled.
                out_valid_d = 1'b1;
                out_a_d     = acc_q[WIDTH_A-1:0];
                out_ovf_d   = |acc_q[ACC_W-1:WIDTH_A];
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign bus.in_ready   = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_a      = out_a_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_badrem = out_badrem_q;
    assign bus.out_div0   = out_div0_q;
endmodule

// File: tb/tb_divider_check_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_check_mul_seq
// Self-checking bench for divider_check_mul_seq: directed cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic model
// (A = Q*B + R, flags from plain comparisons).
// -----------------------------------------------------------------------------
module tb_divider_check_mul_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    divider_check_mul_seq_if bus ();

    divider_check_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, measure latency, check result, optional
    // stall with an in_valid pulse that must be ignored, then release.
    task automatic run_op(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r,
                          input int stall, input bit pulse);
        logic [31:0] full;
        logic [15:0] exp_a;
        logic        exp_ovf, exp_bad, exp_d0;
        int          n;
        full    = 32'(q) * 32'(b) + 32'(r);
        exp_a   = full[15:0];
        exp_ovf = (full > 32'd65535);
        exp_bad = (r >= {8'd0, b});
        exp_d0  = (b == 8'd0);

        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_q      = q;
        bus.in_b      = b;
        bus.in_r      = r;
        bus.out_ready = 1'b0;
        tick();
        // Scramble operands: the block must have latched them.
        bus.in_valid = 1'b0;
        bus.in_q     = 16'($urandom);
        bus.in_b     = 8'($urandom);
        bus.in_r     = 16'($urandom);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd9);
        chk("out_a", 32'(bus.out_a), 32'(exp_a));
        chk("out_ovf", 32'(bus.out_ovf), 32'(exp_ovf));
        chk("out_badrem", 32'(bus.out_badrem), 32'(exp_bad));
        chk("out_div0", 32'(bus.out_div0), 32'(exp_d0));

        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 1) begin
                bus.in_valid = 1'b1;
                bus.in_q     = 16'd3;
                bus.in_b     = 8'd3;
                bus.in_r     = 16'd1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_a", 32'(bus.out_a), 32'(exp_a));
            chk("hold_flags", {29'd0, bus.out_ovf, bus.out_badrem, bus.out_div0},
                {29'd0, exp_ovf, exp_bad, exp_d0});
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        if (pulse) begin
            repeat (12) tick();
            chk("pulse_dropped", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rq, rr;
        logic [7:0]  rb;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_q      = 16'd0;
        bus.in_b      = 8'd0;
        bus.in_r      = 16'd0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_a", 32'(bus.out_a), 32'd0);
        chk("rst_flags", {29'd0, bus.out_ovf, bus.out_badrem, bus.out_div0}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed cases.
        run_op(16'd142, 8'd7, 16'd6, 0, 1'b0);
        run_op(16'hFFFF, 8'hFF, 16'd0, 1, 1'b0);
        run_op(16'd10, 8'd5, 16'd5, 0, 1'b0);
        run_op(16'h1234, 8'd0, 16'd3, 0, 1'b0);
        // Backpressure with a dropped in_valid pulse.
        run_op(16'd300, 8'd200, 16'd17, 5, 1'b1);

        // Reset in the middle of the multiply.
        bus.in_valid = 1'b1;
        bus.in_q     = 16'h0055;
        bus.in_b     = 8'h33;
        bus.in_r     = 16'h0080;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready_hi", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_a", 32'(bus.out_a), 32'd0);
        chk("midrst_flags", {29'd0, bus.out_ovf, bus.out_badrem, bus.out_div0}, 32'd0);
        run_op(16'd1, 8'd1, 16'd0, 0, 1'b0);

        // Randomized operands, mixing legal and illegal remainders.
        for (int k = 0; k < 24; k++) begin
            rq = 16'($urandom);
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                rr = 16'($urandom_range(0, 255));
            end else begin
                rr = 16'($urandom);
            end
            run_op(rq, rb, rr, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
